// File: rtl/mmio_write_buffer.sv
// Posted-write FIFO that drains LSU stores to an aw/w/b write port, one transaction in flight.
// Optional combinational bypass into an idle buffer: define MMIO_WBUF_BYPASS_EN.
module mmio_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_aw_valid,
  input  logic                     out_aw_ready,
  output logic [ADDR_W-1:0]        out_waddr,
  output logic                     out_w_valid,
  input  logic                     out_w_ready,
  output logic [DATA_W-1:0]        out_wdata,
  input  logic                     out_b_valid,
  output logic                     out_b_ready,
  input  logic [1:0]               out_b_resp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {SEND, WAIT_B} state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_aw_done;
  logic               r_w_done;
  logic               r_err;
  logic [ADDR_W-1:0]  r_addr_mem [DEPTH];
  logic [DATA_W-1:0]  r_data_mem [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_head_valid;

  assign w_full       = (r_count == FULL);
  assign w_push       = in_valid & ~w_full;
  assign w_pop        = (r_state == WAIT_B) & out_b_valid;
  assign w_head_valid = (r_count != '0) & (r_state == SEND);
  assign w_aw_hs      = out_aw_valid & out_aw_ready;
  assign w_w_hs       = out_w_valid & out_w_ready;

`ifdef MMIO_WBUF_BYPASS_EN
  // An idle buffer forwards the incoming store in the same cycle; it is still queued below.
  logic w_byp;
  assign w_byp        = in_valid & (r_count == '0) & (r_state == SEND) & ~r_aw_done & ~r_w_done;
  assign out_aw_valid = (w_head_valid & ~r_aw_done) | w_byp;
  assign out_w_valid  = (w_head_valid & ~r_w_done) | w_byp;
  assign out_waddr    = w_byp ? in_addr : r_addr_mem[r_rptr];
  assign out_wdata    = w_byp ? in_data : r_data_mem[r_rptr];
`else
  assign out_aw_valid = w_head_valid & ~r_aw_done;
  assign out_w_valid  = w_head_valid & ~r_w_done;
  assign out_waddr    = r_addr_mem[r_rptr];
  assign out_wdata    = r_data_mem[r_rptr];
`endif

  assign in_ready    = ~w_full;
  assign out_b_ready = (r_state == WAIT_B);
  assign count       = r_count;
  assign err         = r_err;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= in_addr;
      r_data_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= SEND;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        SEND: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          // Address and data may complete in either order or together.
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= WAIT_B;
        end
        WAIT_B: begin
          if (out_b_valid) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= SEND;
            if (out_b_resp != 2'b00) r_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_write_buffer.sv
// Scoreboard bench for mmio_write_buffer: stores queued on push, matched on aw/w, retired on B.
module tb_mmio_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              out_aw_valid;
  logic              out_aw_ready;
  logic [ADDR_W-1:0] out_waddr;
  logic              out_w_valid;
  logic              out_w_ready;
  logic [DATA_W-1:0] out_wdata;
  logic              out_b_valid;
  logic              out_b_ready;
  logic [1:0]        out_b_resp;
  logic [CW-1:0]     count;
  logic              err;

  mmio_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready), .out_waddr(out_waddr),
    .out_w_valid(out_w_valid), .out_w_ready(out_w_ready), .out_wdata(out_wdata),
    .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_resp(out_b_resp),
    .count(count), .err(err)
  );

  always #5 clock = ~clock;

  int          n_checks;
  int          n_errors;
  ent_t        q[$];
  logic [31:0] drained[$];
  logic        mon_en, last_push, aw_seen, w_seen, exp_err;
  logic        rnd_ready, rnd_b;
  int          b_idx, err_idx, max_count;

  // One clock: model/compare at the falling edge, then advance and drive the responder.
  task automatic tick();
    logic exp_awv, exp_wv, exp_br;
    @(negedge clock);
    last_push = 1'b0;
    if (!mon_en) begin
      q.delete();
      aw_seen = 1'b0;
      w_seen  = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_awv = (q.size() != 0) && !aw_seen;
      exp_wv  = (q.size() != 0) && !w_seen;
      exp_br  = aw_seen && w_seen;
      n_checks++;
      if (int'(count) !== q.size()) begin
        n_errors++;
        $display("FAIL count got %0d want %0d at %0t", count, q.size(), $time);
      end
      n_checks++;
      if (err !== exp_err) begin
        n_errors++;
        $display("FAIL err got %b want %b at %0t", err, exp_err, $time);
      end
      n_checks++;
      if (in_ready !== (q.size() < DEPTH)) begin
        n_errors++;
        $display("FAIL in_ready got %b want %b at %0t", in_ready, (q.size() < DEPTH), $time);
      end
      n_checks++;
      if ({out_aw_valid, out_w_valid, out_b_ready} !== {exp_awv, exp_wv, exp_br}) begin
        n_errors++;
        $display("FAIL aw_w_b_flags got %b%b%b want %b%b%b at %0t", out_aw_valid, out_w_valid,
                 out_b_ready, exp_awv, exp_wv, exp_br, $time);
      end
      if (out_aw_valid && q.size() != 0) begin
        n_checks++;
        if (out_waddr !== q[0].a) begin
          n_errors++;
          $display("FAIL waddr got %h want %h at %0t", out_waddr, q[0].a, $time);
        end
      end
      if (out_w_valid && q.size() != 0) begin
        n_checks++;
        if (out_wdata !== q[0].d) begin
          n_errors++;
          $display("FAIL wdata got %h want %h at %0t", out_wdata, q[0].d, $time);
        end
      end
      if (int'(count) > max_count) max_count = int'(count);
      if (out_aw_valid && out_aw_ready) aw_seen = 1'b1;
      if (out_w_valid && out_w_ready)   w_seen  = 1'b1;
      if (out_b_valid && out_b_ready && q.size() != 0) begin
        drained.push_back(q[0].d);
        q.pop_front();
        if (out_b_resp != 2'b00) exp_err = 1'b1;
        b_idx++;
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
      if (in_valid && in_ready) begin
        q.push_back('{a: in_addr, d: in_data});
        last_push = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    if (rnd_ready) begin
      out_aw_ready = 1'($urandom_range(0, 1));
      out_w_ready  = 1'($urandom_range(0, 1));
    end
    if (rnd_b) out_b_valid = ($urandom_range(0, 3) != 0);
    out_b_resp = (b_idx == err_idx) ? 2'd2 : 2'd0;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d, input int bound);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (last_push) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL push_timeout got 0 want 1 data %h", d);
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (count == '0 && q.size() == 0) break;
      tick();
    end
    n_checks++;
    if (count !== '0) begin
      n_errors++;
      $display("FAIL drain_timeout got count %0d want 0", count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mon_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    n_checks++;
    if ({count, in_ready, out_aw_valid, out_w_valid, out_b_ready, err} !== {CW'(0), 5'b10000}) begin
      n_errors++;
      $display("FAIL reset_state got cnt %0d rdy %b aw %b w %b b %b err %b want 0 1 0 0 0 0",
               count, in_ready, out_aw_valid, out_w_valid, out_b_ready, err);
    end
    mon_en = 1'b1;
    err_idx = b_idx;
    out_b_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_b_valid = 1'b0;
    err_idx = -1;
    n_checks++;
    if (err !== 1'b0 || count !== '0) begin
      n_errors++;
      $display("FAIL idle_b_ignored got err %b cnt %0d want 0 0", err, count);
    end
  endtask

  task automatic test_single();
    int base;
    base = drained.size();
    out_aw_ready = 1'b1; out_w_ready = 1'b1; out_b_valid = 1'b0;
    in_valid = 1'b1; in_addr = 32'ha00003f8; in_data = 32'h41;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_aw_valid, out_w_valid} !== 2'b11 || out_waddr !== 32'ha00003f8 || out_wdata !== 32'h41) begin
      n_errors++;
      $display("FAIL single_present got %b%b %h %h want 11 a00003f8 00000041",
               out_aw_valid, out_w_valid, out_waddr, out_wdata);
    end
    tick();
    n_checks++;
    if ({out_aw_valid, out_w_valid, out_b_ready} !== 3'b001 || count !== CW'(1)) begin
      n_errors++;
      $display("FAIL single_wait_b got %b%b%b cnt %0d want 001 cnt 1",
               out_aw_valid, out_w_valid, out_b_ready, count);
    end
    out_b_valid = 1'b1;
    tick();
    out_b_valid = 1'b0;
    n_checks++;
    if (count !== '0 || out_b_ready !== 1'b0 || err !== 1'b0 || drained.size() != base + 1) begin
      n_errors++;
      $display("FAIL single_done got cnt %0d b %b err %b drained %0d want 0 0 0 %0d",
               count, out_b_ready, err, drained.size(), base + 1);
    end else begin
      n_checks++;
      if (drained[base] !== 32'h41) begin
        n_errors++;
        $display("FAIL single_data got %h want 00000041", drained[base]);
      end
    end
  endtask

  task automatic test_split();
    out_aw_ready = 1'b1; out_w_ready = 1'b0; out_b_valid = 1'b0;
    in_valid = 1'b1; in_addr = 32'h1000; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_aw_valid, out_w_valid} !== 2'b11) begin
      n_errors++;
      $display("FAIL split_c1 got %b%b want 11", out_aw_valid, out_w_valid);
    end
    tick();
    out_aw_ready = 1'b0;
    for (int c = 2; c <= 3; c++) begin
      n_checks++;
      if ({out_aw_valid, out_w_valid, out_b_ready} !== 3'b010 || out_wdata !== 32'h55) begin
        n_errors++;
        $display("FAIL split_hold c%0d got %b%b%b %h want 010 00000055",
                 c, out_aw_valid, out_w_valid, out_b_ready, out_wdata);
      end
      tick();
    end
    out_w_ready = 1'b1;
    n_checks++;
    if (out_w_valid !== 1'b1 || out_b_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL split_c4 got w %b b %b want 1 0", out_w_valid, out_b_ready);
    end
    tick();
    out_w_ready = 1'b0;
    n_checks++;
    if (out_b_ready !== 1'b1 || out_w_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL split_c5 got b %b w %b want 1 0", out_b_ready, out_w_valid);
    end
    out_b_valid = 1'b1;
    tick();
    out_b_valid = 1'b0;
    out_aw_ready = 1'b1; out_w_ready = 1'b1;
    n_checks++;
    if (count !== '0) begin
      n_errors++;
      $display("FAIL split_done got cnt %0d want 0", count);
    end
  endtask

  task automatic test_fill();
    int base, base_b, bcnt;
    logic accepted;
    base = drained.size(); base_b = b_idx; accepted = 1'b0; bcnt = -1;
    out_aw_ready = 1'b1; out_w_ready = 1'b1; out_b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 32'h2000 + 32'(i * 4); in_data = 32'h30 + 32'(i);
      tick();
    end
    n_checks++;
    if (in_ready !== 1'b0 || count !== CW'(4)) begin
      n_errors++;
      $display("FAIL fill_full got rdy %b cnt %0d want 0 4", in_ready, count);
    end
    in_addr = 32'h2010; in_data = 32'h34;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || count !== CW'(4)) begin
      n_errors++;
      $display("FAIL fill_stall got rdy %b cnt %0d want 0 4", in_ready, count);
    end
    out_b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_push) begin
        accepted = 1'b1;
        bcnt = b_idx - base_b;
        break;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (!accepted || bcnt != 1) begin
      n_errors++;
      $display("FAIL fill_fifth got accepted %b after %0d B want 1 after 1", accepted, bcnt);
    end
    drain(60);
    out_b_valid = 1'b0;
    n_checks++;
    if (drained.size() != base + 5) begin
      n_errors++;
      $display("FAIL fill_count got %0d want %0d", drained.size() - base, 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (drained[base + i] !== 32'h30 + 32'(i)) begin
          n_errors++;
          $display("FAIL fill_order[%0d] got %h want %h", i, drained[base + i], 32'h30 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int base;
    logic [31:0] sent[10];
    base = drained.size();
    max_count = 0;
    rnd_ready = 1'b1; rnd_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sent[i] = $urandom;
      if ($urandom_range(0, 3) == 0) tick();
      push_word(32'h3000 + 32'(i * 4), sent[i], 100);
    end
    drain(300);
    rnd_ready = 1'b0; rnd_b = 1'b0;
    out_aw_ready = 1'b1; out_w_ready = 1'b1; out_b_valid = 1'b0;
    n_checks++;
    if (max_count > DEPTH) begin
      n_errors++;
      $display("FAIL wrap_max_count got %0d want <= %0d", max_count, DEPTH);
    end
    n_checks++;
    if (drained.size() != base + 10) begin
      n_errors++;
      $display("FAIL wrap_count got %0d want 10", drained.size() - base);
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_checks++;
        if (drained[base + i] !== sent[i]) begin
          n_errors++;
          $display("FAIL wrap_order[%0d] got %h want %h", i, drained[base + i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_error();
    int base;
    base = drained.size();
    out_aw_ready = 1'b1; out_w_ready = 1'b1; out_b_valid = 1'b1;
    err_idx = b_idx + 1;
    for (int i = 0; i < 3; i++) push_word(32'h4000 + 32'(i * 4), 32'h60 + 32'(i), 20);
    drain(40);
    out_b_valid = 1'b0;
    err_idx = -1;
    n_checks++;
    if (err !== 1'b1 || drained.size() != base + 3) begin
      n_errors++;
      $display("FAIL error_sticky got err %b drained %0d want 1 3", err, drained.size() - base);
    end else begin
      n_checks++;
      if (drained[base + 2] !== 32'h62) begin
        n_errors++;
        $display("FAIL error_third got %h want 00000062", drained[base + 2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_aw_ready = 1'b1; out_w_ready = 1'b1; out_b_valid = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'h5000 + 32'(i * 4), 32'h70 + 32'(i), 5);
    tick();
    tick();
    n_checks++;
    if (count !== CW'(3) || out_b_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_pre got cnt %0d b %b want 3 1", count, out_b_ready);
    end
    mon_en = 1'b0;
    reset = 1'b0;
    out_b_valid = 1'b1;
    tick();
    reset = 1'b1;
    n_checks++;
    if ({count, in_ready, out_aw_valid, out_w_valid, out_b_ready, err} !== {CW'(0), 5'b10000}) begin
      n_errors++;
      $display("FAIL rmid_reset got cnt %0d rdy %b aw %b w %b b %b err %b want 0 1 0 0 0 0",
               count, in_ready, out_aw_valid, out_w_valid, out_b_ready, err);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (count !== '0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_late_b got cnt %0d err %b want 0 0", count, err);
    end
    push_word(32'h6000, 32'h77, 5);
    drain(20);
    out_b_valid = 1'b0;
    n_checks++;
    if (drained[drained.size() - 1] !== 32'h77) begin
      n_errors++;
      $display("FAIL rmid_resume got %h want 00000077", drained[drained.size() - 1]);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    b_idx = 0; err_idx = -1; max_count = 0;
    mon_en = 1'b0; last_push = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; exp_err = 1'b0;
    rnd_ready = 1'b0; rnd_b = 1'b0;
    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    out_aw_ready = 1'b0; out_w_ready = 1'b0; out_b_valid = 1'b0; out_b_resp = 2'd0;
    test_reset();
    test_single();
    test_split();
    test_fill();
    test_wrap();
    test_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
